// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: instruction words,
// FSM state encoding and the IF/ID bubble contents.
package fetch_pkg;

  localparam logic [31:0] NOP_WORD          = 32'h0000_0000;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] BUBBLE_INST  = NOP_WORD;
  localparam logic        BUBBLE_VALID = 1'b0;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds, or is
// overwritten with a bubble (NOP, pc_next 0, not valid).
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            bubble_i,
  input  logic [31:0]     inst_i,
  input  logic [PC_W-1:0] pc_next_i,
  output logic [31:0]     inst_o,
  output logic [PC_W-1:0] pc_next_o,
  output logic            valid_o
);

  logic [31:0]     inst_q, inst_d;
  logic [PC_W-1:0] pc_next_q, pc_next_d;
  logic            valid_q, valid_d;

  // Bubble wins over load; with neither asserted the register holds.
  always_comb begin
    inst_d    = inst_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (bubble_i) begin
      inst_d    = BUBBLE_INST;
      pc_next_d = '0;
      valid_d   = BUBBLE_VALID;
    end else if (load_i) begin
      inst_d    = inst_i;
      pc_next_d = pc_next_i;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q    <= BUBBLE_INST;
      pc_next_q <= '0;
      valid_q   <= BUBBLE_VALID;
    end else begin
      inst_q    <= inst_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign inst_o    = inst_q;
  assign pc_next_o = pc_next_q;
  assign valid_o   = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the BOOT/RUN/HALT FSM and feeds
// the IF/ID register from the combinational instruction-memory read.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W        = 32,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_DEPTH   = 32,
  parameter logic [31:0]     HALT_OPCODE = HALT_WORD_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [31:0]     inst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            resume,
  output logic [31:0]     if_id_inst,
  output logic [PC_W-1:0] if_id_pc_next,
  output logic            if_id_valid,
  output logic            halted,
  output logic [31:0]     fetch_count,
  output fetch_state_e    dbg_state
);

  localparam int AW = $clog2(MEM_DEPTH);

  // IF/ID contract: if_id_valid=1 marks a real instruction; a bubble carries
  // NOP with valid=0. stall freezes the register contents and PC together.

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     fetch_count_q, fetch_count_d;
  logic            ifid_load, ifid_bubble;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] target_pc;
  logic            unused_redirect_hi;

  function automatic logic [PC_W-1:0] inc_pc(input logic [PC_W-1:0] p);
    return (p == PC_W'(MEM_DEPTH - 1)) ? '0 : p + PC_W'(1);
  endfunction

  assign pc_inc             = inc_pc(pc_q);
  assign target_pc          = PC_W'(redirect_pc[AW-1:0]);
  assign unused_redirect_hi = ^redirect_pc[PC_W-1:AW];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ifid_load     = 1'b0;
    ifid_bubble   = 1'b0;
    case (state_q)
      ST_BOOT: begin
        ifid_bubble = 1'b1;
        state_d     = ST_RUN;
        if (redirect) pc_d = target_pc;
      end
      ST_RUN: begin
        if (redirect) begin
          pc_d        = target_pc;
          ifid_bubble = 1'b1;
        end else if (!stall) begin
          if (inst == HALT_OPCODE) begin
            // The halt word is swallowed: PC parks on it and nothing is counted.
            ifid_bubble = 1'b1;
            state_d     = ST_HALT;
          end else begin
            ifid_load     = 1'b1;
            pc_d          = pc_inc;
            fetch_count_d = (fetch_count_q == 32'hFFFF_FFFF) ? fetch_count_q
                                                             : fetch_count_q + 32'd1;
          end
        end
      end
      ST_HALT: begin
        ifid_bubble = 1'b1;
        if (redirect) begin
          pc_d    = target_pc;
          state_d = ST_RUN;
        end else if (resume) begin
          pc_d    = pc_inc;
          state_d = ST_RUN;
        end
      end
      default: begin
        ifid_bubble = 1'b1;
        state_d     = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_BOOT;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg #(.PC_W(PC_W)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .inst_i   (inst),
    .pc_next_i(pc_inc),
    .inst_o   (if_id_inst),
    .pc_next_o(if_id_pc_next),
    .valid_o  (if_id_valid)
  );

  assign pc          = pc_q;
  assign halted      = (state_q == ST_HALT);
  assign fetch_count = fetch_count_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS core.
- Owns the PC register and drives it to Inst_Mem's PC input.
- Captures Inst_Mem's combinational Inst output into the IF/ID pipeline register.
- Handles stall, branch/jump redirect, and halt/resume, and keeps a count of fetched instructions.
- PC is word-indexed: sequential fetch increments PC by 1.

Parameters:
PC_W, 32, width of PC and of every PC-valued port
RESET_PC, 0, PC value loaded on reset
MEM_DEPTH, 32, instruction-memory word count; must be a power of 2; all PCs are reduced modulo MEM_DEPTH
HALT_OPCODE, 32'hFFFF_FFFF, instruction word that halts fetch

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
pc  out  PC_W  current fetch address, to Inst_Mem PC
inst  in  32  instruction word from Inst_Mem Inst, combinational on pc
stall  in  1  hazard-unit hold: freeze PC and IF/ID
redirect  in  1  branch-taken or jump from ID; higher priority than stall
redirect_pc  in  PC_W  target word address, valid while redirect=1
resume  in  1  leave HALT, continuing at pc+1
if_id_inst  out  32  registered instruction
if_id_pc_next  out  PC_W  registered pc+1 (wrapped) of the captured instruction
if_id_valid  out  1  IF/ID holds a real instruction
halted  out  1  high while in HALT
fetch_count  out  32  instructions delivered to IF/ID; saturating

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low; reset assertion mid-operation takes effect immediately, regardless of state.
- Reset values:
  - pc=RESET_PC, state=BOOT.
  - if_id_inst=0, if_id_pc_next=0, if_id_valid=0.
  - halted=0, fetch_count=0.
- Wrap rule: inc(p) = 0 if p==MEM_DEPTH-1, else p+1. redirect_pc is reduced to its low log2(MEM_DEPTH) bits, upper bits zero.
- Bubble: if_id_inst=0 (NOP), if_id_pc_next=0, if_id_valid=0.
- FSM states: BOOT, RUN, HALT. Per-cycle priority is rst_n > redirect > stall > halt detect > normal fetch.
- BOOT:
  - Lasts exactly one cycle after reset release; IF/ID stays a bubble and pc holds.
  - Next state is RUN.
  - If redirect=1 in BOOT, pc loads the target and the state still goes to RUN.
- RUN, redirect=1:
  - pc <= target; IF/ID <= bubble; fetch_count holds.
  - Same-cycle stall and HALT_OPCODE are ignored.
- RUN, stall=1 (no redirect): pc, IF/ID and fetch_count all hold.
- RUN, inst==HALT_OPCODE (no stall, no redirect):
  - IF/ID <= bubble; pc holds at the halt address.
  - Next state is HALT; halted=1 from the next cycle.
  - The halt word is never delivered and never counted.
- RUN, normal fetch:
  - if_id_inst <= inst, if_id_pc_next <= inc(pc), if_id_valid <= 1.
  - pc <= inc(pc); fetch_count <= fetch_count+1, saturating at 32'hFFFF_FFFF.
- Latency: the instruction at pc appears on the IF/ID outputs one cycle after pc is presented.
- HALT:
  - IF/ID is a bubble and pc holds; stall is ignored.
  - resume=1: pc <= inc(pc), state -> RUN, halted=0 on the next cycle.
  - redirect=1: pc <= target, state -> RUN, halted=0. If both are asserted, redirect wins.

Decomposition:
- Shared package fetch_pkg:
  - NOP word (32'h0) and HALT_OPCODE default.
  - FSM state encoding: BOOT=2'd0, RUN=2'd1, HALT=2'd2.
  - Bubble constants.
- One sub-module, if_id_reg:
  - Holds the IF/ID register with load, hold, and bubble controls and the asynchronous active-low reset.
  - The parent computes next-PC and runs the FSM.

Test Plan:
Memory is preloaded with word[i]=i for i=0..31 unless stated otherwise.
- Reset/boot: hold rst_n=0 for 3 cycles, release, run 4 cycles. Required: one bubble cycle in BOOT. Then IF/ID inst = 0, 1, 2 with pc_next = 1, 2, 3; valid=1 from the 2nd post-reset edge; fetch_count=3.
- Wrap: redirect to 30, then run free. Required: IF/ID inst sequence 30, 31, 0, 1; if_id_pc_next for inst 31 is 0.
- Stall vs redirect: stall for 2 cycles with pc=7, then assert stall=1 and redirect=1 (target 20) in the same cycle. Required: IF/ID frozen at inst 6 while stalled. The combined cycle yields a bubble, then inst 20; fetch_count does not count the bubble.
- Halt/resume: word[5]=32'hFFFF_FFFF. Required: after inst 4, a bubble; halted=1; pc stays 5 with stall toggled. Pulse resume: halted=0 and the next delivered inst is 6.
- Reset mid-operation: assert rst_n=0 asynchronously mid-cycle while in RUN at pc=12. Required: pc=0, if_id_valid=0 and fetch_count=0 immediately, before the next clk edge.
- Out-of-range redirect: redirect_pc=37. Required: pc=5 and the next delivered inst is 5.
